// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: requester-side controller for the Q12.12 divider wrapper.
//   Accepts tagged operand pairs and issues them to a fixed-latency, in-order
//   divider. A tag FIFO holds each operation's tag and divide-by-zero info
//   while the operation is in the divider. Each returning quotient is paired
//   with the head of the tag FIFO and written into a first-word-fall-through
//   result FIFO.
//   Credit: an operation is accepted only while in-flight ops plus queued
//   results are below DEPTH. This means every divider output has a slot
//   waiting for it, because the divider itself cannot be stalled.
//   The divider latency is not counted here. DEPTH only has to cover it
//   (DEPTH >= latency + 2) so that a continuous stream never stalls.
// Optional build macro: DIV_ISSUE_STATS_EN adds the stat_issued and
//   stat_max_inflight counter ports.
//
// FSM states:
//   state   | meaning
//   S_RUN   | normal operation: accept operands, return results
//   S_DRAIN | flush in progress: no accepts, no output; returning results
//           | are discarded; result FIFO cleared once nothing is in flight

module div_issue_ctrl #(
    parameter int TAG_W = 8,
    parameter int DEPTH = 32
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_dividend,
    input  logic [23:0]              in_divisor,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     divisor_tvalid,
    output logic [23:0]              divisor,
    output logic                     dividend_tvalid,
    output logic [23:0]              dividend,
    input  logic                     div_tvalid,
    input  logic [23:0]              div_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [23:0]              out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_dbz,
    output logic                     err_orphan
`ifdef DIV_ISSUE_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [$clog2(DEPTH):0]   stat_max_inflight
`endif
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int TFW = TAG_W + 2;
    localparam int RFW = 24 + TAG_W + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_rf_clear;
    logic              w_credit;
    logic              w_accept;
    logic              w_ret;
    logic              w_orphan;
    logic              w_rf_push;
    logic              w_rf_pop;

    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     w_inflight_nxt;

    logic [CW-1:0]     r_tf_wptr;
    logic [CW-1:0]     r_tf_rptr;
    logic [CW-1:0]     r_rf_wptr;
    logic [CW-1:0]     r_rf_rptr;
    logic [CW-1:0]     w_rf_cnt;
    logic              w_tf_empty;
    logic              w_rf_empty;

    // tag FIFO entry: {tag, divisor_was_zero, dividend_negative}
    logic [TFW-1:0]    r_tf_mem [DEPTH];
    // result FIFO entry: {quotient, tag, dbz}
    logic [RFW-1:0]    r_rf_mem [DEPTH];

    logic [TFW-1:0]    w_tf_head;
    logic [TFW-1:0]    w_tf_wdata;
    logic [RFW-1:0]    w_rf_head;
    logic [RFW-1:0]    w_rf_wdata;
    logic [TAG_W-1:0]  w_ret_tag;
    logic              w_ret_dbz;
    logic              w_ret_neg;
    logic [23:0]       w_ret_result;

    logic              r_div_tvalid;
    logic [23:0]       r_divisor;
    logic [23:0]       r_dividend;
    logic              r_err_orphan;

    assign w_tf_empty = (r_tf_wptr == r_tf_rptr);
    assign w_rf_empty = (r_rf_wptr == r_rf_rptr);
    assign w_rf_cnt   = r_rf_wptr - r_rf_rptr;
    assign w_credit   = ({1'b0, r_inflight} + {1'b0, w_rf_cnt}) < DEPTH_W;

    assign w_accept   = in_valid & w_in_ready;
    // The divider is in order, so a return always belongs to the oldest tag.
    // A return with no tag outstanding is an orphan (e.g. issued before a reset).
    assign w_ret      = div_tvalid & ~w_tf_empty;
    assign w_orphan   = div_tvalid & w_tf_empty;
    assign w_rf_push  = w_ret & (r_state == S_RUN);
    assign w_rf_pop   = w_out_valid & out_ready;

    assign w_tf_wdata = {in_tag, (in_divisor == 24'h000000), in_dividend[23]};
    assign w_tf_head  = r_tf_mem[r_tf_rptr[PW-1:0]];
    assign w_ret_tag  = w_tf_head[TFW-1:2];
    assign w_ret_dbz  = w_tf_head[1];
    assign w_ret_neg  = w_tf_head[0];

    // The divider's output is meaningless on divide-by-zero; saturate toward the dividend's sign.
    assign w_ret_result = w_ret_dbz ? (w_ret_neg ? 24'h800000 : 24'h7FFFFF) : div_result;
    assign w_rf_wdata   = {w_ret_result, w_ret_tag, w_ret_dbz};
    assign w_rf_head    = r_rf_mem[r_rf_rptr[PW-1:0]];

    // FSM next state and stream handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_rf_clear  = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_in_ready  = w_credit;
                w_out_valid = ~w_rf_empty;
                if (flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_inflight == '0) begin
                    w_rf_clear  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in-flight count: +1 on accept, -1 on matched return, unchanged when both happen
    always_comb begin
        w_inflight_nxt = r_inflight;
        unique case ({w_accept, w_ret})
            2'b10:   w_inflight_nxt = r_inflight + CW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // in-flight counter register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
        end
    end

    // divider request registers: tvalid is high for exactly one cycle per accept
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_div_tvalid <= 1'b0;
            r_divisor    <= '0;
            r_dividend   <= '0;
        end else begin
            r_div_tvalid <= w_accept;
            if (w_accept) begin
                r_divisor  <= in_divisor;
                r_dividend <= in_dividend;
            end
        end
    end

    // tag FIFO pointers; credit keeps it from overflowing
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_tf_wptr <= '0;
            r_tf_rptr <= '0;
        end else begin
            if (w_accept) begin
                r_tf_wptr <= r_tf_wptr + CW'(1);
            end
            if (w_ret) begin
                r_tf_rptr <= r_tf_rptr + CW'(1);
            end
        end
    end

    // tag FIFO storage
    always_ff @(posedge sysclk) begin
        if (w_accept) begin
            r_tf_mem[r_tf_wptr[PW-1:0]] <= w_tf_wdata;
        end
    end

    // result FIFO pointers; the clear at the end of a drain takes priority
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
        end else if (w_rf_clear) begin
            r_rf_wptr <= '0;
            r_rf_rptr <= '0;
        end else begin
            if (w_rf_push) begin
                r_rf_wptr <= r_rf_wptr + CW'(1);
            end
            if (w_rf_pop) begin
                r_rf_rptr <= r_rf_rptr + CW'(1);
            end
        end
    end

    // result FIFO storage
    always_ff @(posedge sysclk) begin
        if (w_rf_push) begin
            r_rf_mem[r_rf_wptr[PW-1:0]] <= w_rf_wdata;
        end
    end

    // sticky orphan-return flag, cleared only by reset
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_err_orphan <= 1'b0;
        end else if (w_orphan) begin
            r_err_orphan <= 1'b1;
        end
    end

`ifdef DIV_ISSUE_STATS_EN
    logic [31:0]   r_stat_issued;
    logic [CW-1:0] r_stat_max_inflight;

    // accept counter (wraps) and in-flight high-water mark
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_stat_issued       <= '0;
            r_stat_max_inflight <= '0;
        end else begin
            if (w_accept) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (w_inflight_nxt > r_stat_max_inflight) begin
                r_stat_max_inflight <= w_inflight_nxt;
            end
        end
    end

    assign stat_issued       = r_stat_issued;
    assign stat_max_inflight = r_stat_max_inflight;
`endif

    assign in_ready        = w_in_ready;
    assign out_valid       = w_out_valid;
    assign divisor_tvalid  = r_div_tvalid;
    assign dividend_tvalid = r_div_tvalid;
    assign divisor         = r_divisor;
    assign dividend        = r_dividend;
    assign out_result      = w_rf_empty ? 24'h000000 : w_rf_head[RFW-1 -: 24];
    assign out_tag         = w_rf_empty ? '0 : w_rf_head[TAG_W:1];
    assign out_dbz         = ~w_rf_empty & w_rf_head[0];
    assign err_orphan      = r_err_orphan;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl with a fixed-latency Q12.12 divider model.
module tb_div_issue_ctrl;

    localparam int L     = 28;
    localparam int TAG_W = 8;
    localparam int DEPTH = 32;
    localparam int PW    = $clog2(DEPTH);

    logic              sysclk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [23:0]       in_dividend = '0;
    logic [23:0]       in_divisor = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              divisor_tvalid;
    logic [23:0]       divisor;
    logic              dividend_tvalid;
    logic [23:0]       dividend;
    logic              div_tvalid;
    logic [23:0]       div_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [23:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_dbz;
    logic              err_orphan;
`ifdef DIV_ISSUE_STATS_EN
    logic [31:0]       stat_issued;
    logic [PW:0]       stat_max_inflight;
`endif

    logic              inj = 1'b0;
    logic [L-1:0]      pv = '0;
    logic [23:0]       pd [L];

    logic [23:0]       q_res [$];
    logic [TAG_W-1:0]  q_tag [$];
    logic              q_dbz [$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    div_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .sysclk          (sysclk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_dividend     (in_dividend),
        .in_divisor      (in_divisor),
        .in_tag          (in_tag),
        .divisor_tvalid  (divisor_tvalid),
        .divisor         (divisor),
        .dividend_tvalid (dividend_tvalid),
        .dividend        (dividend),
        .div_tvalid      (div_tvalid),
        .div_result      (div_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_tag         (out_tag),
        .out_dbz         (out_dbz),
        .err_orphan      (err_orphan)
`ifdef DIV_ISSUE_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_max_inflight (stat_max_inflight)
`endif
    );

    function automatic logic [23:0] q_div(input logic [23:0] a, input logic [23:0] b);
        logic signed [47:0] n;
        logic signed [47:0] d;
        logic signed [47:0] q;
        if (b == 24'h000000) return 24'h000000;
        n = $signed({{12{a[23]}}, a, 12'h000});
        d = $signed({{24{b[23]}}, b});
        q = n / d;
        return q[23:0];
    endfunction

    // divider model: L-stage pipeline, not reset, so ops survive a controller reset
    always @(posedge sysclk) begin
        pv    <= {pv[L-2:0], divisor_tvalid};
        pd[0] <= q_div(dividend, divisor);
        for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
    end
    assign div_tvalid = pv[L-1] | inj;
    assign div_result = pd[L-1];

    // record every handshaken output word
    always begin
        @(negedge sysclk);
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            q_res.push_back(out_result);
            q_tag.push_back(out_tag);
            q_dbz.push_back(out_dbz);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [TAG_W-1:0] t,
                        input int budget, output bit ok, output int waited);
        in_dividend = a;
        in_divisor  = b;
        in_tag      = t;
        in_valid    = 1'b1;
        ok          = 1'b0;
        waited      = 0;
        while (!ok && waited < budget) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(negedge sysclk);
            if (!ok) waited++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_res.size() < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check_eq(tag, q_res.size(), n);
    endtask

    task automatic clear_q();
        q_res.delete();
        q_tag.delete();
        q_dbz.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int w;
        int acc;
        int stalls;
        int n;
        int bad;
        int lat;

        // reset state
        repeat (3) @(negedge sysclk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_tvalid", divisor_tvalid, 0);
        check_eq("rst_dvd_tvalid", dividend_tvalid, 0);
        check_eq("rst_divisor", divisor, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_err_orphan", err_orphan, 0);
        rst = 1'b0;
        @(negedge sysclk);
        check_eq("rst_in_ready", in_ready, 1);

        // 1. single op, latency and divider handshake
        out_ready = 1'b1;
        send(24'h003000, 24'h001800, 8'd5, 10, ok, w);
        check_eq("t1_accept", ok, 1);
        check_eq("t1_divisor_tvalid", divisor_tvalid, 1);
        check_eq("t1_dividend_tvalid", dividend_tvalid, 1);
        check_eq("t1_divisor", divisor, 24'h001800);
        check_eq("t1_dividend", dividend, 24'h003000);
        @(negedge sysclk);
        lat = 1;
        check_eq("t1_tvalid_drop", divisor_tvalid, 0);
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge sysclk);
            lat++;
        end
        check_eq("t1_latency", lat, L + 1);
        check_eq("t1_result", out_result, 24'h002000);
        check_eq("t1_tag", out_tag, 5);
        check_eq("t1_dbz", out_dbz, 0);
        wait_results(1, 10, "t1_count");
        clear_q();

        // 2. 40 back-to-back ops, i.0 / 1.0
        stalls = 0;
        acc    = 0;
        for (int i = 0; i < 40; i++) begin
            send(24'(i * 4096), 24'h001000, 8'(i), 50, ok, w);
            stalls += w;
            acc    += int'(ok);
        end
        check_eq("t2_stalls", stalls, 0);
        check_eq("t2_accepted", acc, 40);
        wait_results(40, 200, "t2_count");
        for (int i = 0; i < 40 && i < q_res.size(); i++) begin
            check_eq($sformatf("t2_res%0d", i), q_res[i], 24'(i * 4096));
            check_eq($sformatf("t2_tag%0d", i), q_tag[i], i);
        end
        clear_q();

        // 3. consumer stalled: exactly DEPTH accepted, then all drain in order
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 33; i++) begin
            send(24'(i * 4096), 24'h001000, 8'(100 + i), 40, ok, w);
            acc += int'(ok);
        end
        check_eq("t3_accepted", acc, DEPTH);
        check_eq("t3_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        wait_results(32, 200, "t3_count");
        for (int i = 0; i < 32 && i < q_res.size(); i++) begin
            check_eq($sformatf("t3_res%0d", i), q_res[i], 24'(i * 4096));
            check_eq($sformatf("t3_tag%0d", i), q_tag[i], 100 + i);
        end
        @(negedge sysclk);
        check_eq("t3_out_valid_end", out_valid, 0);
        check_eq("t3_in_ready_end", in_ready, 1);
        clear_q();

        // 4. divide by zero and signed values
        send(24'h001000, 24'h000000, 8'd1, 10, ok, w);
        send(24'hFFF000, 24'h000000, 8'd2, 10, ok, w);
        send(24'hFFD000, 24'h001800, 8'd3, 10, ok, w);
        send(24'h001000, 24'h003000, 8'd4, 10, ok, w);
        wait_results(4, 100, "t4_count");
        if (q_res.size() >= 4) begin
            check_eq("t4_pos_dbz_res", q_res[0], 24'h7FFFFF);
            check_eq("t4_pos_dbz_flag", q_dbz[0], 1);
            check_eq("t4_neg_dbz_res", q_res[1], 24'h800000);
            check_eq("t4_neg_dbz_flag", q_dbz[1], 1);
            check_eq("t4_neg_res", q_res[2], 24'hFFE000);
            check_eq("t4_neg_flag", q_dbz[2], 0);
            check_eq("t4_third_res", q_res[3], 24'h000555);
            check_eq("t4_tag", q_tag[3], 4);
        end
        clear_q();

        // 5. flush with 10 in flight and 5 queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(24'h001000, 24'h001000, 8'(200 + i), 10, ok, w);
        repeat (L + 8) @(negedge sysclk);
        check_eq("t5_queued_valid", out_valid, 1);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            send(24'h002000, 24'h001000, 8'(210 + i), 10, ok, w);
            acc += int'(ok);
        end
        check_eq("t5_accepted", acc, 10);
        flush = 1'b1;
        @(negedge sysclk);
        flush = 1'b0;
        n   = 0;
        bad = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            if (out_valid !== 1'b0) bad++;
            flush = (n == 5);
            @(negedge sysclk);
            n++;
        end
        flush = 1'b0;
        check_eq("t5_drain_cycles", n, L + 1);
        check_eq("t5_out_valid_in_drain", bad, 0);
        check_eq("t5_fifo_cleared", out_valid, 0);
        check_eq("t5_no_orphan", err_orphan, 0);
        out_ready = 1'b1;
        send(24'h002000, 24'h001000, 8'd77, 10, ok, w);
        wait_results(1, 100, "t5_count");
        if (q_res.size() >= 1) begin
            check_eq("t5_res", q_res[0], 24'h002000);
            check_eq("t5_tag", q_tag[0], 77);
        end
        clear_q();

        // 6. orphan return, stickiness, async reset
        inj = 1'b1;
        @(negedge sysclk);
        inj = 1'b0;
        check_eq("t6_orphan_set", err_orphan, 1);
        repeat (5) @(negedge sysclk);
        check_eq("t6_orphan_sticky", err_orphan, 1);
        check_eq("t6_orphan_dropped", out_valid, 0);
        #2 rst = 1'b1;
        #1 check_eq("t6_async_clear", err_orphan, 0);
        @(negedge sysclk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(24'h001000, 24'h001000, 8'(i), 10, ok, w);
        repeat (4) @(negedge sysclk);
        #2 rst = 1'b1;
        #1 check_eq("t6_rst_tvalid", divisor_tvalid, 0);
        @(negedge sysclk);
        rst = 1'b0;
        n = 0;
        while (err_orphan !== 1'b1 && n < 60) begin
            @(negedge sysclk);
            n++;
        end
        check_eq("t6_rst_orphan", err_orphan, 1);
        repeat (5) @(negedge sysclk);
        check_eq("t6_rst_no_output", q_res.size(), 0);
        check_eq("t6_rst_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
